frame_double_buffer: RTL and testbench

Single-clock, parametrised double-buffered frame store for the video controller. It holds two full frames of DATAW-bit pixels: the drawing side writes the back bank while scan-out reads the front bank. Banks swap only at a scan-out frame boundary, so the display never shows a half-drawn frame. A built-in clear engine fills the back bank with a constant colour.

---
 rtl/frame_double_buffer_if.sv | 38 +++
 rtl/frame_double_buffer.sv | 149 ++++++++++++++
 tb/tb_frame_double_buffer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_double_buffer_if.sv
// Bus bundle for the double-buffered frame store: drawing-side write port,
// scan-out read port, frame/swap control and clear-engine control.
interface frame_double_buffer_if #(
  parameter int DATAW      = 24,
  parameter int addrLength = 20
) ();

  logic                  writeEn;
  logic [addrLength-1:0] writePointer;
  logic [DATAW-1:0]      dataIn;
  logic                  wrReady;
  logic                  frameDone;
  logic                  readEn;
  logic [addrLength-1:0] readPointer;
  logic [DATAW-1:0]      dataOut;
  logic                  readValid;
  logic                  scanEnd;
  logic                  clearReq;
  logic [DATAW-1:0]      clearColor;
  logic                  clearBusy;
  logic                  swapPending;
  logic                  frontSel;

  // Drawing side / timing generator / test harness.
  modport master (
    output writeEn, writePointer, dataIn, frameDone,
    output readEn, readPointer, scanEnd, clearReq, clearColor,
    input  wrReady, dataOut, readValid, clearBusy, swapPending, frontSel
  );

  // Frame store.
  modport slave (
    input  writeEn, writePointer, dataIn, frameDone,
    input  readEn, readPointer, scanEnd, clearReq, clearColor,
    output wrReady, dataOut, readValid, clearBusy, swapPending, frontSel
  );

endinterface

// File: rtl/frame_double_buffer.sv
// Double-buffered frame store. Drawing writes the back bank, scan-out reads
// the front bank; banks swap only when scan-out reports end of frame.
// A clear engine can flood the back bank with a constant colour.
module frame_double_buffer #(
  parameter int DATAW      = 24,
  parameter int HRES       = 640,
  parameter int VRES       = 480,
  parameter int addrLength = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  frame_double_buffer_if.slave   bus
);

  localparam int NPIX = HRES * VRES;
  localparam int PIXW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [addrLength:0] NPIX_EXT = (addrLength + 1)'(NPIX);
  localparam logic [PIXW-1:0]     LAST_PIX = PIXW'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_PENDING
  } state_t;

  state_t           state_q, state_d;
  logic             front_sel_q, front_sel_d;
  logic [PIXW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [DATAW-1:0] clr_color_q, clr_color_d;

  logic [DATAW-1:0] dout_q;
  logic             rvalid_q;

  // Both banks; first index is the bank, second the pixel.
  logic [DATAW-1:0] mem [0:1][0:NPIX-1];

  logic             wr_in_range;
  logic             rd_in_range;
  logic [PIXW-1:0]  wr_idx;
  logic [PIXW-1:0]  rd_idx;

  logic             mem_we;
  logic [PIXW-1:0]  mem_waddr;
  logic [DATAW-1:0] mem_wdata;
  logic             back_sel;

  assign wr_in_range = {1'b0, bus.writePointer} < NPIX_EXT;
  assign rd_in_range = {1'b0, bus.readPointer}  < NPIX_EXT;
  assign wr_idx      = bus.writePointer[PIXW-1:0];
  assign rd_idx      = bus.readPointer[PIXW-1:0];
  assign back_sel    = ~front_sel_q;

  // Control registers: FSM state, bank select, clear counter and colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      clr_cnt_q   <= clr_cnt_d;
    end
    clr_color_q <= clr_color_d;
  end

  // Next-state logic: frameDone outranks clearReq in IDLE; CLEAR and
  // PENDING ignore further requests until they complete.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.frameDone) begin
          state_d = S_PENDING;
        end else if (bus.clearReq) begin
          state_d     = S_CLEAR;
          clr_color_d = bus.clearColor;
          clr_cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == LAST_PIX) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_PENDING: begin
        if (bus.scanEnd) begin
          state_d     = S_IDLE;
          front_sel_d = ~front_sel_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Back-bank write port shared by the clear engine and external writes;
  // the two are mutually exclusive because writes are only taken in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = bus.dataIn;
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = clr_color_q;
      end else if (state_q == S_IDLE && bus.writeEn && wr_in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  // Back-bank storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[back_sel][mem_waddr] <= mem_wdata;
    end
  end

  // Front-bank registered read; out-of-range pixels read as zero and the
  // output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.readEn;
      if (bus.readEn) begin
        dout_q <= rd_in_range ? mem[front_sel_q][rd_idx] : '0;
      end
    end
  end

  assign bus.wrReady     = (state_q == S_IDLE);
  assign bus.clearBusy   = (state_q == S_CLEAR);
  assign bus.swapPending = (state_q == S_PENDING);
  assign bus.frontSel    = front_sel_q;
  assign bus.dataOut     = dout_q;
  assign bus.readValid   = rvalid_q;

endmodule

// File: tb/tb_frame_double_buffer.sv
// Bench for frame_double_buffer: directed sequences plus randomized traffic,
// read data checked through a scoreboard against a bank-array model.
module tb_frame_double_buffer;

  localparam int DATAW = 24;
  localparam int HRES  = 8;
  localparam int VRES  = 4;
  localparam int AW    = 6;
  localparam int NPIX  = HRES * VRES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_double_buffer_if #(.DATAW(DATAW), .addrLength(AW)) bus ();

  frame_double_buffer #(
    .DATAW(DATAW), .HRES(HRES), .VRES(VRES), .addrLength(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DATAW-1:0] data;
    int               cyc;
  } rd_t;

  rd_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: two pixel arrays plus which one is shown, and the
  // pending-swap / clearing flags.
  logic [DATAW-1:0] m_mem [0:1][0:NPIX-1];
  bit               m_front;
  bit               m_pend;
  bit               m_clr;
  int               m_cnt;
  logic [DATAW-1:0] m_color;
  bit               m_rv;
  logic [DATAW-1:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    rst              = 1'b0;
    bus.writeEn      = 1'b0;
    bus.writePointer = '0;
    bus.dataIn       = '0;
    bus.frameDone    = 1'b0;
    bus.readEn       = 1'b0;
    bus.readPointer  = '0;
    bus.scanEnd      = 1'b0;
    bus.clearReq     = 1'b0;
    bus.clearColor   = '0;
  endtask

  // Apply the effect of the inputs currently driven to the model.
  task automatic model_step();
    rd_t e;
    int  wp, rp;
    wp = int'(bus.writePointer);
    rp = int'(bus.readPointer);
    if (rst) begin
      m_front = 1'b0;
      m_pend  = 1'b0;
      m_clr   = 1'b0;
      m_cnt   = 0;
      m_rv    = 1'b0;
      m_dout  = '0;
    end else begin
      if (bus.readEn) begin
        e.data = (rp < NPIX) ? m_mem[m_front][rp] : '0;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        m_dout = e.data;
      end
      m_rv = bus.readEn;
      if (m_clr) begin
        m_mem[!m_front][m_cnt] = m_color;
        m_cnt++;
        if (m_cnt == NPIX) m_clr = 1'b0;
      end else if (m_pend) begin
        if (bus.scanEnd) begin
          m_front = !m_front;
          m_pend  = 1'b0;
        end
      end else begin
        if (bus.writeEn && wp < NPIX) m_mem[!m_front][wp] = bus.dataIn;
        if (bus.frameDone) begin
          m_pend = 1'b1;
        end else if (bus.clearReq) begin
          m_clr   = 1'b1;
          m_color = bus.clearColor;
          m_cnt   = 0;
        end
      end
    end
  endtask

  // One clock with the currently driven inputs, then check control outputs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("wrReady",     32'(bus.wrReady),     32'(!m_pend && !m_clr));
    chk("clearBusy",   32'(bus.clearBusy),   32'(m_clr));
    chk("swapPending", 32'(bus.swapPending), 32'(m_pend));
    chk("frontSel",    32'(bus.frontSel),    32'(m_front));
    chk("readValid",   32'(bus.readValid),   32'(m_rv));
    if (!m_rv) chk("dataOut_hold", 32'(bus.dataOut), 32'(m_dout));
  endtask

  task automatic write_px(input int a, input logic [DATAW-1:0] d);
    idle_inputs();
    bus.writeEn      = 1'b1;
    bus.writePointer = AW'(a);
    bus.dataIn       = d;
    tick();
  endtask

  task automatic read_px(input int a);
    idle_inputs();
    bus.readEn      = 1'b1;
    bus.readPointer = AW'(a);
    tick();
  endtask

  task automatic pulse_frame_done();
    idle_inputs();
    bus.frameDone = 1'b1;
    tick();
  endtask

  task automatic pulse_scan_end();
    idle_inputs();
    bus.scanEnd = 1'b1;
    tick();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      tick();
    end
  endtask

  // Monitor: every delivered read is matched against the oldest expectation.
  initial begin
    rd_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.readValid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_unexpected: readValid with dataOut %0h, expected no read (cycle %0d)",
                   bus.dataOut, cyc);
        end else begin
          e = sb.pop_front();
          chk("rd_data",    32'(bus.dataOut), 32'(e.data));
          chk("rd_latency", 32'(cyc),         32'(e.cyc));
        end
      end
    end
  end

  initial begin
    idle_inputs();
    m_front = 1'b0; m_pend = 1'b0; m_clr = 1'b0; m_cnt = 0;
    m_rv = 1'b0; m_dout = '0; m_color = '0;

    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_dataOut", 32'(bus.dataOut), 32'h0);

    // Pattern into back bank 1, swap, read back
    for (int a = 0; a < NPIX; a++) write_px(a, DATAW'(a) ^ 24'h5A5A5A);
    pulse_frame_done();
    write_px(5, 24'h123456);
    write_px(6, 24'h654321);
    pulse_scan_end();
    chk("swap_front1", 32'(bus.frontSel), 32'h1);
    for (int a = 0; a < NPIX; a++) read_px(a);

    // Fill bank 0, swap back, read both
    for (int a = 0; a < NPIX; a++) write_px(a, DATAW'($urandom));
    pulse_frame_done();
    pulse_scan_end();
    read_px(5);
    read_px(6);
    pulse_frame_done();
    pulse_scan_end();
    read_px(5);

    // Clear the back bank while scanning the front bank
    idle_inputs();
    bus.clearReq   = 1'b1;
    bus.clearColor = 24'h00FF00;
    tick();
    for (int i = 0; i < NPIX; i++) read_px($urandom_range(0, NPIX - 1));
    idle_cycles(2);
    pulse_frame_done();
    pulse_scan_end();
    for (int a = 0; a < NPIX; a++) read_px(a);

    // frameDone with clearReq: pending wins, no clear
    idle_inputs();
    bus.frameDone  = 1'b1;
    bus.clearReq   = 1'b1;
    bus.clearColor = 24'hABCDEF;
    tick();
    idle_cycles(3);
    pulse_scan_end();

    // frameDone with scanEnd from IDLE: swap waits for the next scanEnd
    idle_inputs();
    bus.frameDone = 1'b1;
    bus.scanEnd   = 1'b1;
    tick();
    idle_cycles(3);
    pulse_scan_end();
    read_px(3);

    // Out-of-range write and read
    write_px(NPIX, 24'hDEAD01);
    write_px(NPIX + 5, 24'hDEAD02);
    write_px(0, 24'h111111);
    pulse_frame_done();
    pulse_scan_end();
    read_px(0);
    read_px(NPIX);
    read_px(2 ** AW - 1);
    read_px(0);

    // Reset mid-clear
    read_px(1);
    idle_inputs();
    bus.clearReq   = 1'b1;
    bus.clearColor = 24'h0F0F0F;
    tick();
    idle_cycles(20);
    idle_inputs();
    rst        = 1'b1;
    bus.readEn = 1'b1;
    tick();
    chk("midclr_clearBusy", 32'(bus.clearBusy), 32'h0);
    chk("midclr_frontSel",  32'(bus.frontSel),  32'h0);
    chk("midclr_readValid", 32'(bus.readValid), 32'h0);
    chk("midclr_dataOut",   32'(bus.dataOut),   32'h0);
    chk("midclr_wrReady",   32'(bus.wrReady),   32'h1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      rst              = ($urandom_range(0, 299) == 0);
      bus.writeEn      = $urandom_range(0, 1);
      bus.writePointer = AW'($urandom_range(0, NPIX + 4));
      bus.dataIn       = DATAW'($urandom);
      bus.frameDone    = ($urandom_range(0, 19) == 0);
      bus.scanEnd      = ($urandom_range(0, 5) == 0);
      bus.clearReq     = ($urandom_range(0, 29) == 0);
      bus.clearColor   = DATAW'($urandom);
      bus.readEn       = $urandom_range(0, 1);
      bus.readPointer  = AW'($urandom_range(0, NPIX + 2));
      tick();
    end

    idle_cycles(3);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
